store_write_unit: RTL
=====================

# store_write_unit

Store-side data path of the MIPS pipeline and write-direction counterpart of the load-alignment logic in the memory stage. Accepts store requests (sb, sh, sw, swl, swr) from the execute stage and converts each to a word-aligned address, byte strobes and lane-shifted write data. Holds requests in a small in-order store buffer and drains them to the data SRAM over a req/addr_ok write handshake. Reports buffer occupancy so the hazard logic can hold loads until earlier stores have drained.

## Interface
- DEPTH, 2, store-buffer entries; power of two, ≥2. CW = log2(DEPTH)+1.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- es_st_valid  in  1  store request valid
- es_st_ready  out  1  buffer can accept a request this cycle
- es_st_width  in  2  01 byte, 10 half, 11 word; ignored when es_st_lr≠00
- es_st_lr  in  2  {swl, swr}; 00 for a normal store
- es_st_addr  in  32  byte address
- es_st_data  in  32  register rt value
- flush  in  1  exception/eret flush; blocks acceptance this cycle
- wr_req  out  1  write request to data SRAM
- wr_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- wr_wstrb  out  4  byte enables, bit i = byte lane i (little-endian)
- wr_wdata  out  32  lane-aligned write data
- wr_addr_ok  in  1  SRAM accepts the current request
- sb_empty  out  1  no buffered stores
- sb_count  out  CW  buffered entries, 0..DEPTH

## Operation
- Push when es_st_valid && es_st_ready && !flush. es_st_ready = (sb_count < DEPTH). It does not depend on flush or es_st_valid.
- Alignment is computed at push time and the result is stored. With off = addr[1:0]:
  - byte: wstrb = 0001<<off; wdata = {4{data[7:0]}}.
  - half: wstrb = 0011<<(2·off[1]); wdata = {2{data[15:0]}}. addr[0] is ignored because misalignment is trapped upstream.
  - word: wstrb = 1111; wdata = data.
  - swl (lr=10):
    - off 0: strb 0001, data>>24
    - off 1: strb 0011, data>>16
    - off 2: strb 0111, data>>8
    - off 3: strb 1111, data
  - swr (lr=01):
    - off 0: strb 1111, data
    - off 1: strb 1110, data<<8
    - off 2: strb 1100, data<<16
    - off 3: strb 1000, data<<24
  - lr=11 is never issued. If it arrives, it is handled as swl.
- The buffer is a circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH. Requests leave strictly in order.
- wr_req = !sb_empty. wr_addr/wr_wstrb/wr_wdata present the head entry and are forced to 0 when empty.
- Pop when wr_req && wr_addr_ok. While wr_req && !wr_addr_ok, all wr_* outputs hold stable.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. This is legal at any count below DEPTH.
- Full: ready is low. A pop in the same cycle does not re-open ready until the next cycle; there is no same-cycle bypass.
- Flush: entries already in the buffer are committed and still drain. Only the same-cycle push is suppressed.

## Timing
- Reset values: sb_count=0, sb_empty=1, es_st_ready=1, wr_req=0, wr_addr=0, wr_wstrb=0, wr_wdata=0. Pointers are 0.
- Reset mid-operation discards every entry. wr_req is 0 in the cycle after reset is sampled.
- Latency: a push in cycle N gives wr_req=1 with that entry's fields in cycle N+1 if the buffer was empty. There is no combinational path from es_st_* to wr_*.
- Throughput: one push and one pop per cycle are sustained when wr_addr_ok is held high.
- sb_count and sb_empty are registered and reflect pushes and pops from the previous edge.
- es_st_ready is a combinational function of sb_count only.

## Test plan
- Byte/half lanes:
  - sb with addr 0x1003, data 0xAABBCCDD → wr_addr 0x1000, wstrb 1000, wdata 0xDDDDDDDD.
  - sh with addr 0x1002 → wstrb 1100, wdata 0xCCDDCCDD.
- swl/swr sweep, data 0x11223344:
  - swl off 1 → strb 0011, wdata 0x00001122.
  - swr off 2 → strb 1100, wdata 0x33440000.
  - Check all 8 cases.
- Backpressure: push 3 stores with wr_addr_ok=0 → ready drops after 2 (DEPTH=2), outputs stay stable. Release addr_ok → drains in order, one per cycle, then sb_empty=1.
- Simultaneous push/pop at count=1 with addr_ok=1 over 10 cycles → count stays 1, order preserved, pointers wrap correctly.
- Flush: flush=1 with es_st_valid=1 while 1 entry is buffered → new store is not accepted, buffered entry still writes.
- Reset while 2 entries are pending and wr_req=1 → next cycle wr_req=0, sb_count=0, es_st_ready=1, and no stale write afterwards.

Source files
------------

// File: rtl/store_write_unit.sv
// store_write_unit: store alignment and in-order store buffer draining to the data SRAM
//   clk, reset                         clock, synchronous active-high reset
//   es_st_valid/ready                  store request handshake from execute
//   es_st_width/lr/addr/data           store kind (byte/half/word, swl/swr), byte address, rt value
//   flush                              suppresses this cycle's push only
//   wr_req/addr/wstrb/wdata/addr_ok    SRAM write handshake, head of buffer
//   sb_empty, sb_count                 buffer occupancy for load hazard logic
module store_write_unit #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          es_st_valid,
    output logic          es_st_ready,
    input  logic [1:0]    es_st_width,
    input  logic [1:0]    es_st_lr,
    input  logic [31:0]   es_st_addr,
    input  logic [31:0]   es_st_data,
    input  logic          flush,
    output logic          wr_req,
    output logic [31:0]   wr_addr,
    output logic [3:0]    wr_wstrb,
    output logic [31:0]   wr_wdata,
    input  logic          wr_addr_ok,
    output logic          sb_empty,
    output logic [CW-1:0] sb_count
);
    logic [31:0]   addr_q [DEPTH];
    logic [3:0]    strb_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] head, tail;
    logic [1:0]    off, inv;
    logic [3:0]    strb;
    logic [31:0]   data;
    logic          push, pop;

    assign off = es_st_addr[1:0];
    assign inv = 2'd3 - off;

    // lr=11 never issues; lr[1] alone selects swl so it falls into the swl path
    always_comb begin
        strb = es_st_lr[1] ? 4'b1111 >> inv :
               es_st_lr[0] ? 4'b1111 << off :
               es_st_width == 2'b01 ? 4'b0001 << off :
               es_st_width == 2'b10 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
        data = es_st_lr[1] ? es_st_data >> {inv, 3'b000} :
               es_st_lr[0] ? es_st_data << {off, 3'b000} :
               es_st_width == 2'b01 ? {4{es_st_data[7:0]}} :
               es_st_width == 2'b10 ? {2{es_st_data[15:0]}} : es_st_data;
    end

    assign es_st_ready = sb_count < CW'(DEPTH);
    assign sb_empty    = sb_count == '0;
    assign wr_req      = !sb_empty;
    assign wr_addr     = wr_req ? addr_q[head] : '0;
    assign wr_wstrb    = wr_req ? strb_q[head] : '0;
    assign wr_wdata    = wr_req ? data_q[head] : '0;
    assign push        = es_st_valid && es_st_ready && !flush;
    assign pop         = wr_req && wr_addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            sb_count <= '0;
        end else begin
            if (push) begin
                addr_q[tail] <= {es_st_addr[31:2], 2'b00};
                strb_q[tail] <= strb;
                data_q[tail] <= data;
                tail         <= tail + AW'(1);
            end
            if (pop)
                head <= head + AW'(1);
            sb_count <= sb_count + CW'(push) - CW'(pop);
        end
    end
endmodule
